// File: rtl/sram_pkg.sv
// Shared constants for the accelerator's memory flavours built on sram_multiport.
package sram_pkg;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DEPTH  = 8192;

    localparam int GM_DATA_W = 128;
    localparam int WM_DATA_W = 128;
    localparam int IM_DATA_W = 8;
    localparam int OM_DATA_W = 16;

    // Marks an unreachable node in the output memory.
    localparam logic [15:0] DIST_INF = 16'hFFFF;

    // Index bits needed to address a DEPTH-entry array (at least one).
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_read_port.sv
// One asynchronous read port: range-checks the address and indexes the storage array.
module sram_read_port
    import sram_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = OM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_i [0:DEPTH-1],
    output logic [DATA_W-1:0] data_o
);

    localparam int IDX_W = idxWidth(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Addresses past the populated depth read as zero rather than aliasing.
    always_comb begin
        data_o = '0;
        if ({1'b0, addr_i} < DEPTH_LIM) begin
            data_o = mem_i[addr_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/sram_multiport.sv
// Behavioural SRAM: one array, one or two asynchronous read ports, optional synchronous write port.
module sram_multiport
    import sram_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = OM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int NUM_RD = 2,
    parameter int HAS_WR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [DATA_W-1:0] WriteBus,
    input  logic [ADDR_W-1:0] ReadAddress1,
    output logic [DATA_W-1:0] ReadBus1,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic [DATA_W-1:0] ReadBus2
);

    localparam int IDX_W = idxWidth(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Name and bounds are fixed so benches can preload and inspect it directly.
    logic [DATA_W-1:0] Register [0:DEPTH-1];

    logic [ADDR_W-1:0] rdAddr [0:1];
    logic [DATA_W-1:0] rdData [0:1];

    if (NUM_RD < 1 || NUM_RD > 2) begin : g_bad_num_rd
        $error("sram_multiport: NUM_RD must be 1 or 2");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("sram_multiport: DEPTH exceeds 2**ADDR_W");
    end

    assign rdAddr[0] = ReadAddress1;
    assign rdAddr[1] = ReadAddress2;

    for (genvar g = 0; g < 2; g++) begin : g_rd
        if (g < NUM_RD) begin : g_port
            sram_read_port #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_port (
                .addr_i (rdAddr[g]),
                .mem_i  (Register),
                .data_o (rdData[g])
            );
        end else begin : g_absent
            assign rdData[g] = '0;
        end
    end

    assign ReadBus1 = rdData[0];
    assign ReadBus2 = rdData[1];

    // Reset only blocks writes; it never clears contents so preloads survive power-on.
    if (HAS_WR != 0) begin : g_wr
        logic wrInRange;
        assign wrInRange = ({1'b0, WriteAddress} < DEPTH_LIM);

        always_ff @(posedge clock) begin
            if (!reset && WE && wrInRange) begin
                Register[WriteAddress[IDX_W-1:0]] <= WriteBus;
            end
        end
    end

endmodule

// File: tb/tb_sram_multiport.sv
// Self-checking bench for sram_multiport across the 1R, 2R, 1R1W, 2R1W and short-depth flavours.
module tb_sram_multiport;
    import sram_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    // Input memory: 1R, 8-bit, read-only
    logic        imWe = 1'b0;
    logic [12:0] imWa = '0, imRa1 = '0, imRa2 = '0;
    logic [7:0]  imWd = '0, imRb1, imRb2;
    // Graph memory: 2R, 128-bit, read-only
    logic         gmWe = 1'b0;
    logic [12:0]  gmWa = '0, gmRa1 = '0, gmRa2 = '0;
    logic [127:0] gmWd = '0, gmRb1, gmRb2;
    // Output memory: 1R1W, 16-bit
    logic        omWe = 1'b0;
    logic [12:0] omWa = '0, omRa1 = '0, omRa2 = '0;
    logic [15:0] omWd = '0, omRb1, omRb2;
    // Working memory: 2R1W, 128-bit
    logic         wmWe = 1'b0;
    logic [12:0]  wmWa = '0, wmRa1 = '0, wmRa2 = '0;
    logic [127:0] wmWd = '0, wmRb1, wmRb2;
    // Short memory: 4096 words behind a 13-bit address
    logic        smWe = 1'b0;
    logic [12:0] smWa = '0, smRa1 = '0, smRa2 = '0;
    logic [15:0] smWd = '0, smRb1, smRb2;

    logic [15:0]  omSnap [0:8191];
    logic [127:0] wmModel [0:31];
    logic [15:0]  smModel [0:4095];

    sram_multiport #(.ADDR_W(13), .DATA_W(8), .DEPTH(8192), .NUM_RD(1), .HAS_WR(0)) u_im (
        .clock(clock), .reset(reset), .WE(imWe), .WriteAddress(imWa), .WriteBus(imWd),
        .ReadAddress1(imRa1), .ReadBus1(imRb1), .ReadAddress2(imRa2), .ReadBus2(imRb2));

    sram_multiport #(.ADDR_W(13), .DATA_W(128), .DEPTH(8192), .NUM_RD(2), .HAS_WR(0)) u_gm (
        .clock(clock), .reset(reset), .WE(gmWe), .WriteAddress(gmWa), .WriteBus(gmWd),
        .ReadAddress1(gmRa1), .ReadBus1(gmRb1), .ReadAddress2(gmRa2), .ReadBus2(gmRb2));

    sram_multiport #(.ADDR_W(13), .DATA_W(16), .DEPTH(8192), .NUM_RD(1), .HAS_WR(1)) u_om (
        .clock(clock), .reset(reset), .WE(omWe), .WriteAddress(omWa), .WriteBus(omWd),
        .ReadAddress1(omRa1), .ReadBus1(omRb1), .ReadAddress2(omRa2), .ReadBus2(omRb2));

    sram_multiport #(.ADDR_W(13), .DATA_W(128), .DEPTH(8192), .NUM_RD(2), .HAS_WR(1)) u_wm (
        .clock(clock), .reset(reset), .WE(wmWe), .WriteAddress(wmWa), .WriteBus(wmWd),
        .ReadAddress1(wmRa1), .ReadBus1(wmRb1), .ReadAddress2(wmRa2), .ReadBus2(wmRb2));

    sram_multiport #(.ADDR_W(13), .DATA_W(16), .DEPTH(4096), .NUM_RD(2), .HAS_WR(1)) u_sm (
        .clock(clock), .reset(reset), .WE(smWe), .WriteAddress(smWa), .WriteBus(smWd),
        .ReadAddress1(smRa1), .ReadBus1(smRb1), .ReadAddress2(smRa2), .ReadBus2(smRb2));

    task automatic test_reset();
        u_om.Register[3] <= 16'h0042;
        @(negedge clock);
        reset = 1'b1;
        omWe = 1'b1; omWa = 13'd3; omWd = 16'h0000; omRa1 = 13'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (omRb1 !== 16'h0042) $display("[TB] FAIL reset_read_live: got %h want %h", omRb1, 16'h0042);
            else passed++;
        end
        checks++;
        if (u_om.Register[3] !== 16'h0042) $display("[TB] FAIL reset_no_write: got %h want %h", u_om.Register[3], 16'h0042);
        else passed++;
        checks++;
        if (omRb2 !== 16'h0000) $display("[TB] FAIL om_rb2_tied: got %h want 0", omRb2);
        else passed++;
        @(negedge clock);
        omWe = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_read_1r();
        u_im.Register[0]    <= 8'h3A;
        u_im.Register[8191] <= 8'h7F;
        #1;
        imRa1 = 13'd0;
        #1;
        checks++;
        if (imRb1 !== 8'h3A) $display("[TB] FAIL im_read_0: got %h want 3a", imRb1);
        else passed++;
        imRa1 = 13'd8191;
        #1;
        checks++;
        if (imRb1 !== 8'h7F) $display("[TB] FAIL im_read_8191: got %h want 7f", imRb1);
        else passed++;
        checks++;
        if (imRb2 !== 8'h00) $display("[TB] FAIL im_rb2_tied: got %h want 0", imRb2);
        else passed++;
    endtask

    task automatic test_dual_read();
        u_gm.Register[5] <= 128'h1;
        u_gm.Register[9] <= '1;
        #1;
        gmRa1 = 13'd5; gmRa2 = 13'd9;
        #1;
        checks++;
        if (gmRb1 !== 128'h1) $display("[TB] FAIL gm_port1: got %h want 1", gmRb1);
        else passed++;
        checks++;
        if (gmRb2 !== {128{1'b1}}) $display("[TB] FAIL gm_port2: got %h want all-ones", gmRb2);
        else passed++;
        gmRa1 = 13'd9;
        #1;
        checks++;
        if (gmRb1 !== {128{1'b1}} || gmRb2 !== {128{1'b1}})
            $display("[TB] FAIL gm_same_addr: got %h / %h want all-ones", gmRb1, gmRb2);
        else passed++;
    endtask

    task automatic test_write_1r1w();
        u_om.Register[100] <= 16'h1234;
        @(negedge clock);
        omWe = 1'b1; omWa = 13'd100; omWd = 16'hFFFF; omRa1 = 13'd100;
        #1;
        checks++;
        if (omRb1 !== 16'h1234) $display("[TB] FAIL rdw_before_edge: got %h want 1234", omRb1);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (omRb1 !== 16'hFFFF) $display("[TB] FAIL rdw_after_edge: got %h want ffff", omRb1);
        else passed++;
        @(negedge clock);
        omWe = 1'b0; omWd = 16'h0012;
        @(posedge clock);
        #1;
        checks++;
        if (u_om.Register[100] !== 16'hFFFF || omRb1 !== 16'hFFFF)
            $display("[TB] FAIL we_low_hold: got %h want ffff", u_om.Register[100]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int diffs = 0;
        @(negedge clock);
        for (int i = 0; i < 8192; i++) omSnap[i] = u_om.Register[i];
        omWe = 1'b1; omWa = 13'd8191; omWd = 16'h0007;
        @(negedge clock);
        omWa = 13'd0; omWd = 16'h0008;
        @(negedge clock);
        omWe = 1'b0;
        checks++;
        if (u_om.Register[8191] !== 16'h0007) $display("[TB] FAIL b2b_top: got %h want 0007", u_om.Register[8191]);
        else passed++;
        checks++;
        if (u_om.Register[0] !== 16'h0008) $display("[TB] FAIL b2b_bottom: got %h want 0008", u_om.Register[0]);
        else passed++;
        for (int i = 1; i < 8191; i++) if (u_om.Register[i] !== omSnap[i]) diffs++;
        checks++;
        if (diffs !== 0) $display("[TB] FAIL b2b_untouched: got %0d changed words want 0", diffs);
        else passed++;
    endtask

    task automatic test_out_of_range();
        int diffs = 0;
        logic [15:0] exp1, exp2;
        for (int i = 0; i < 4096; i++) begin
            smModel[i] = 16'($urandom());
            u_sm.Register[i] <= smModel[i];
        end
        @(negedge clock);
        smRa1 = 13'd5000; smRa2 = 13'd4095;
        #1;
        checks++;
        if (smRb1 !== 16'h0000) $display("[TB] FAIL oor_read: got %h want 0", smRb1);
        else passed++;
        checks++;
        if (smRb2 !== smModel[4095]) $display("[TB] FAIL oor_last_word: got %h want %h", smRb2, smModel[4095]);
        else passed++;
        smWe = 1'b1; smWa = 13'd5000; smWd = 16'hBEEF;
        @(negedge clock);
        smWe = 1'b0;
        for (int i = 0; i < 4096; i++) if (u_sm.Register[i] !== smModel[i]) diffs++;
        checks++;
        if (diffs !== 0) $display("[TB] FAIL oor_write_ignored: got %0d changed words want 0", diffs);
        else passed++;
        for (int n = 0; n < 150; n++) begin
            @(negedge clock);
            smWe = 1'($urandom_range(0, 1));
            smWa = 13'($urandom_range(0, 8191));
            smWd = 16'($urandom());
            smRa1 = 13'($urandom_range(0, 8191));
            smRa2 = (n % 3 == 0) ? smWa : 13'($urandom_range(0, 8191));
            #1;
            exp1 = (smRa1 < 13'd4096) ? smModel[smRa1] : 16'h0000;
            exp2 = (smRa2 < 13'd4096) ? smModel[smRa2] : 16'h0000;
            checks++;
            if (smRb1 !== exp1 || smRb2 !== exp2)
                $display("[TB] FAIL sm_random[%0d]: got %h/%h want %h/%h", n, smRb1, smRb2, exp1, exp2);
            else passed++;
            @(posedge clock);
            if (smWe && smWa < 13'd4096) smModel[smWa] = smWd;
        end
        @(negedge clock);
        smWe = 1'b0;
    endtask

    task automatic test_random_2r1w();
        for (int i = 0; i < 32; i++) begin
            wmModel[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            u_wm.Register[i] <= wmModel[i];
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 7) == 0);
            wmWe  = 1'($urandom_range(0, 1));
            wmWa  = 13'($urandom_range(0, 31));
            wmWd  = {$urandom(), $urandom(), $urandom(), $urandom()};
            wmRa1 = 13'($urandom_range(0, 31));
            wmRa2 = (n % 4 == 0) ? wmWa : 13'($urandom_range(0, 31));
            #1;
            checks++;
            if (wmRb1 !== wmModel[wmRa1] || wmRb2 !== wmModel[wmRa2])
                $display("[TB] FAIL wm_random[%0d]: got %h/%h want %h/%h",
                         n, wmRb1, wmRb2, wmModel[wmRa1], wmModel[wmRa2]);
            else passed++;
            @(posedge clock);
            if (wmWe && !reset) wmModel[wmWa] = wmWd;
        end
        @(negedge clock);
        reset = 1'b0;
        wmWe  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_1r();
        test_dual_read();
        test_write_1r1w();
        test_back_to_back();
        test_out_of_range();
        test_random_2r1w();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_multiport.md
Name: sram_multiport

Overview:
- Parameterised behavioural SRAM: one storage array, up to two asynchronous read ports, optional single synchronous write port.
- It is the single implementation behind the accelerator's memory flavours:
  - 1R: input memory, 8-bit.
  - 2R: graph memory, 128-bit.
  - 1R1W: output memory, 16-bit.
  - 2R1W: working memory, 128-bit.
- Contents are preloadable by the bench through hierarchical access to the storage array.

Parameters:
- ADDR_W, 13, address width in bits.
- DATA_W, 16, word width in bits; 8, 16 and 128 are in use.
- DEPTH, 8192, number of words; must be <= 2**ADDR_W.
- NUM_RD, 2, number of read ports; legal values 1 or 2.
- HAS_WR, 1, write port present (1) or read-only array (0).

Ports:
- clock  in  1  rising-edge clock for writes.
- reset  in  1  synchronous, active-high.
- WE  in  1  write enable; ignored when HAS_WR=0.
- WriteAddress  in  ADDR_W  write address.
- WriteBus  in  DATA_W  write data.
- ReadAddress1  in  ADDR_W  read port 1 address.
- ReadBus1  out  DATA_W  read port 1 data.
- ReadAddress2  in  ADDR_W  read port 2 address; ignored when NUM_RD=1.
- ReadBus2  out  DATA_W  read port 2 data; driven 0 when NUM_RD=1.

Behaviour:
- Storage:
  - The array is named Register, declared [0:DEPTH-1], each entry DATA_W wide.
  - The name and bounds are fixed so that $readmemh/$writememh and direct indexing (Register[i]) work from the bench.
- Reads:
  - Asynchronous and combinational: ReadBusN = Register[ReadAddressN] in the same delta.
  - Zero-cycle latency; no clock involvement.
  - The two read ports are fully independent; the same address on both ports returns identical data.
- Writes, when HAS_WR=1:
  - On posedge clock with WE=1 and reset=0: Register[WriteAddress] <= WriteBus.
  - At most one write per cycle.
  - WE=0 leaves all contents unchanged.
- Read-during-write, same address:
  - Before the edge, the read returns the old word.
  - After the edge, it returns the new word.
  - No bypass of write data into the read path.
- Reset:
  - Synchronous and active-high.
  - It does NOT clear the array, so preloaded contents survive the power-on reset.
  - While reset=1, writes are suppressed even if WE=1.
  - Read ports stay live during reset.
  - There are no output registers, so there is no output reset value; ReadBus always reflects the array.
- Out-of-range addresses, when DEPTH < 2**ADDR_W:
  - Read returns all-zeros.
  - Write is ignored.
- Uninitialised words read as X in simulation; there is no implicit zero fill.
- HAS_WR=0: the write logic is not generated. clock, reset, WE, WriteAddress and WriteBus remain as ports but are unused.
- Parameter checks, enforced by elaboration-time $error:
  - NUM_RD outside {1,2}.
  - DEPTH > 2**ADDR_W.

Decomposition:
- Shared package sram_pkg holds:
  - MEM_ADDR_W=13 and MEM_DEPTH=8192.
  - Per-memory widths: GM_DATA_W=128, WM_DATA_W=128, IM_DATA_W=8, OM_DATA_W=16.
  - The sentinel constant DIST_INF=16'hFFFF used by output-memory consumers.
- Natural sub-module: sram_read_port (address range check plus array index mux), instantiated once per read port by a generate loop.
- Existing SRAM_1R, SRAM_2R, SRAM_1R1W and SRAM_2R1W callers become thin wrappers that tie off unused ports.

Test Plan:
- Preload via $readmemh with Register[0]=8'h3A and Register[8191]=8'h7F (NUM_RD=1, HAS_WR=0, DATA_W=8). Drive ReadAddress1=0, then 8191 → ReadBus1=8'h3A, then 8'h7F, each with no clock edge.
- 2R, 128-bit, preload Register[5]=128'h1, Register[9]=128'hFFFF…F:
  - ReadAddress1=5, ReadAddress2=9 → ReadBus1=1, ReadBus2=all-ones, simultaneously.
  - Both addresses set to 9 → both buses all-ones.
- 1R1W, 16-bit, reset=0:
  - WE=1, WriteAddress=100, WriteBus=16'hFFFF, ReadAddress1=100.
  - Before the edge, ReadBus1 = old value; after the posedge, ReadBus1 = 16'hFFFF.
  - Then WE=0 with WriteBus=16'h0012 → Register[100] stays 16'hFFFF.
- Preload Register[3]=16'h0042, hold reset=1 across two posedges with WE=1, WriteAddress=3, WriteBus=16'h0000:
  - Register[3] remains 16'h0042.
  - ReadBus1 reads 16'h0042 throughout reset.
- Write 16'h0007 at address 8191, then 16'h0008 at address 0 on the next cycle. $writememh dump shows both words and all other words untouched.
- DEPTH=4096 with ADDR_W=13: read at address 5000 → 0; write at 5000 alters no word in 0..4095.
